// File: rtl/rtc_pkg.sv
// Shared RTC definitions: register addresses, field/phase enums and decode helpers.
// Used by both the write sequencer and the parameter reader.
package rtc_pkg;

  localparam logic [7:0] ADDR_S      = 8'h21;
  localparam logic [7:0] ADDR_M      = 8'h22;
  localparam logic [7:0] ADDR_H      = 8'h23;
  localparam logic [7:0] ADDR_D      = 8'h24;
  localparam logic [7:0] ADDR_ME     = 8'h25;
  localparam logic [7:0] ADDR_A      = 8'h26;
  localparam logic [7:0] ADDR_ST     = 8'h41;
  localparam logic [7:0] ADDR_MT     = 8'h42;
  localparam logic [7:0] ADDR_HT     = 8'h43;
  localparam logic [7:0] ADDR_COMMIT = 8'hF1;

  typedef enum logic [3:0] {
    F_S, F_M, F_H, F_D, F_ME, F_A, F_ST, F_MT, F_HT, F_COMMIT
  } field_e;

  typedef enum logic [2:0] {
    PH_IDLE, PH_A_SETUP, PH_A_STB, PH_A_HOLD, PH_D_SETUP, PH_D_STB, PH_D_HOLD, PH_NEXT
  } bus_phase_e;

  typedef enum logic [1:0] {SQ_IDLE, SQ_RUN, SQ_DONE} seq_state_e;

  typedef struct packed {
    logic ad;
    logic cs;
    logic wr;
    logic dir_dat;
    logic oe;
  } pins_t;

  function automatic logic [7:0] field_addr(input field_e f);
    case (f)
      F_S:     return ADDR_S;
      F_M:     return ADDR_M;
      F_H:     return ADDR_H;
      F_D:     return ADDR_D;
      F_ME:    return ADDR_ME;
      F_A:     return ADDR_A;
      F_ST:    return ADDR_ST;
      F_MT:    return ADDR_MT;
      F_HT:    return ADDR_HT;
      default: return ADDR_COMMIT;
    endcase
  endfunction

  // Lowest enabled field at or above 'from'; the commit write when none remain.
  function automatic field_e next_field(input logic [8:0] mask, input int from);
    field_e f;
    f = F_COMMIT;
    for (int i = 8; i >= 0; i--)
      if (i >= from && mask[i]) f = field_e'(4'(i));
    return f;
  endfunction

  function automatic pins_t phase_pins(input bus_phase_e p);
    pins_t r;
    case (p)
      PH_A_SETUP, PH_A_HOLD: r = '{ad: 1'b0, cs: 1'b0, wr: 1'b1, dir_dat: 1'b0, oe: 1'b1};
      PH_A_STB:              r = '{ad: 1'b0, cs: 1'b0, wr: 1'b0, dir_dat: 1'b0, oe: 1'b1};
      PH_D_SETUP, PH_D_HOLD: r = '{ad: 1'b1, cs: 1'b0, wr: 1'b1, dir_dat: 1'b1, oe: 1'b1};
      PH_D_STB:              r = '{ad: 1'b1, cs: 1'b0, wr: 1'b0, dir_dat: 1'b1, oe: 1'b1};
      default:               r = '{ad: 1'b1, cs: 1'b1, wr: 1'b1, dir_dat: 1'b0, oe: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rtc_write_sequencer_if.sv
// RTC multiplexed address/data bus pins as driven by one bus owner.
interface rtc_write_sequencer_if;
  logic       AD;
  logic       CS;
  logic       RD;
  logic       WR;
  logic       Dir_Dat;
  logic [7:0] bus_out;
  logic       bus_oe;

  modport master (output AD, CS, RD, WR, Dir_Dat, bus_out, bus_oe);
  modport slave  (input  AD, CS, RD, WR, Dir_Dat, bus_out, bus_oe);
endinterface

// File: rtl/rtc_bus_cycle.sv
// One RTC bus write: six T_PH-clock phases plus a one-cycle gap, all pins registered.
// go is taken in IDLE or in the gap so back-to-back writes need no extra cycle.
module rtc_bus_cycle
  import rtc_pkg::*;
#(
  parameter int T_PH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  input  logic [7:0]                   addr,
  input  logic [7:0]                   data,
  rtc_write_sequencer_if.master        bus,
  output logic                         cycle_done
);

  localparam int CW = (T_PH > 1) ? $clog2(T_PH) : 1;

  bus_phase_e    ph, ph_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    addr_q, data_q, addr_n, data_n;
  logic          last;
  pins_t         pins_n;

  assign last = (cnt == CW'(T_PH - 1));

  always_comb begin
    ph_n   = ph;
    cnt_n  = cnt;
    addr_n = addr_q;
    data_n = data_q;
    case (ph)
      PH_IDLE, PH_NEXT: begin
        ph_n = PH_IDLE;
        if (go) begin
          ph_n   = PH_A_SETUP;
          cnt_n  = '0;
          addr_n = addr;
          data_n = data;
        end
      end
      PH_D_HOLD: begin
        if (last) begin
          ph_n  = PH_NEXT;
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      end
      default: begin
        if (last) begin
          ph_n  = bus_phase_e'(ph + 3'd1);
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      end
    endcase
    pins_n = phase_pins(ph_n);
  end

  // Pins are decoded from the state being entered so they change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph          <= PH_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      bus.AD      <= 1'b1;
      bus.CS      <= 1'b1;
      bus.RD      <= 1'b1;
      bus.WR      <= 1'b1;
      bus.Dir_Dat <= 1'b0;
      bus.bus_out <= '0;
      bus.bus_oe  <= 1'b0;
      cycle_done  <= 1'b0;
    end else begin
      ph          <= ph_n;
      cnt         <= cnt_n;
      addr_q      <= addr_n;
      data_q      <= data_n;
      bus.AD      <= pins_n.ad;
      bus.CS      <= pins_n.cs;
      bus.RD      <= 1'b1;
      bus.WR      <= pins_n.wr;
      bus.Dir_Dat <= pins_n.dir_dat;
      bus.bus_out <= pins_n.oe ? (pins_n.dir_dat ? data_n : addr_n) : 8'h00;
      bus.bus_oe  <= pins_n.oe;
      cycle_done  <= (ph_n == PH_NEXT);
    end
  end

endmodule

// File: rtl/rtc_write_sequencer.sv
// Snapshots nine BCD fields on start and walks the enabled ones through rtc_bus_cycle,
// finishing with a fixed commit write.
module rtc_write_sequencer
  import rtc_pkg::*;
#(
  parameter int         T_PH        = 4,
  parameter logic [7:0] COMMIT_ADDR = ADDR_COMMIT,
  parameter logic [7:0] COMMIT_DATA = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8:0]            wr_mask,
  input  logic [7:0]            s_e,
  input  logic [7:0]            m_e,
  input  logic [7:0]            h_e,
  input  logic [7:0]            d_e,
  input  logic [7:0]            me_e,
  input  logic [7:0]            a_e,
  input  logic [7:0]            st_e,
  input  logic [7:0]            mt_e,
  input  logic [7:0]            ht_e,
  rtc_write_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done
);

  seq_state_e      seq;
  field_e          field, go_field;
  logic [8:0]      mask_q;
  logic [8:0][7:0] snap, live;
  logic            go, cycle_done;
  logic [7:0]      go_addr, go_data;

  assign live = {ht_e, mt_e, st_e, a_e, me_e, d_e, h_e, m_e, s_e};

  // The first write takes its data straight from the inputs being snapshotted.
  always_comb begin
    go       = 1'b0;
    go_field = field;
    if (seq == SQ_IDLE && start) begin
      go       = 1'b1;
      go_field = next_field(wr_mask, 0);
    end else if (seq == SQ_RUN && cycle_done && field != F_COMMIT) begin
      go       = 1'b1;
      go_field = next_field(mask_q, int'(field) + 1);
    end
    go_addr = (go_field == F_COMMIT) ? COMMIT_ADDR : field_addr(go_field);
    if (go_field == F_COMMIT) go_data = COMMIT_DATA;
    else if (seq == SQ_IDLE)  go_data = live[go_field];
    else                      go_data = snap[go_field];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq    <= SQ_IDLE;
      field  <= F_S;
      mask_q <= '0;
      snap   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (seq)
        SQ_IDLE: if (start) begin
          seq    <= SQ_RUN;
          busy   <= 1'b1;
          snap   <= live;
          mask_q <= wr_mask;
          field  <= go_field;
        end
        SQ_RUN: if (cycle_done) begin
          if (field == F_COMMIT) begin
            seq  <= SQ_DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else field <= go_field;
        end
        default: seq <= SQ_IDLE;
      endcase
    end
  end

  rtc_bus_cycle #(.T_PH(T_PH)) u_bus_cycle (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .addr       (go_addr),
    .data       (go_data),
    .bus        (bus),
    .cycle_done (cycle_done)
  );

endmodule

// File: doc/rtc_write_sequencer.md
Name: rtc_write_sequencer

Overview:
- Write-side counterpart of the RTC parameter reader: pushes time, date and timer parameters into the RTC over its multiplexed address/data bus (AD, CS, RD, WR).
- Snapshots nine BCD parameter bytes on a start pulse and issues one bus write per enabled field, then a fixed commit write.
- Sits beside the reader in the RTC controller. The top-level arbiter grants the bus to only one of the two at a time.

Parameters:
- T_PH, 4, clocks per bus phase (min 1).
- COMMIT_ADDR, 8'hF1, RTC register written last to latch the new values.
- COMMIT_DATA, 8'h00, data byte for the commit write.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- wr_mask  in  9  per-field enable: bit0 s, bit1 m, bit2 h, bit3 d, bit4 me, bit5 a, bit6 st, bit7 mt, bit8 ht.
- s_e, m_e, h_e, d_e, me_e, a_e, st_e, mt_e, ht_e  in  8 each  BCD values to write.
- AD  out  1  0 = address phase, 1 = data phase.
- CS  out  1  chip select, active low.
- RD  out  1  read strobe, active low; held at 1 by this block.
- WR  out  1  write strobe, active low.
- Dir_Dat  out  1  bus source select: 0 = address, 1 = data.
- bus_out  out  8  value driven onto the RTC bus.
- bus_oe  out  1  1 = this block drives the bus.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset (async, any state): state = IDLE; AD=1, CS=1, RD=1, WR=1, Dir_Dat=0, bus_out=0, bus_oe=0, busy=0, done=0.
  - Field index and snapshot registers are cleared to 0.
  - Any in-flight write is abandoned with no partial strobe; WR and CS rise in the same cycle.
- IDLE, start=1:
  - Capture all nine bytes and wr_mask.
  - Set the field index to the lowest set mask bit; if no bit is set, go directly to the commit write.
  - busy rises next cycle.
  - start while busy is ignored; inputs that change while busy have no effect.
- Field order and RTC addresses: s 21h, m 22h, h 23h, d 24h, me 25h, a 26h, st 41h, mt 42h, ht 43h, then commit at COMMIT_ADDR.
  - Masked-out fields are skipped and cost zero bus cycles.
- One bus write = six phases, each T_PH clocks. Signal levels per phase:
  - A_SETUP: CS=0, AD=0, WR=1, Dir_Dat=0, bus_oe=1, bus_out=addr.
  - A_STB: as A_SETUP but WR=0.
  - A_HOLD: WR=1; address still driven.
  - D_SETUP: AD=1, Dir_Dat=1, bus_out=data, WR=1.
  - D_STB: WR=0.
  - D_HOLD: WR=1; data still driven.
  - CS stays 0 across all six phases.
  - After D_HOLD: CS=1 and bus_oe=0 for one gap cycle (NEXT state).
- Transitions:
  - IDLE -> A_SETUP -> A_STB -> A_HOLD -> D_SETUP -> D_STB -> D_HOLD -> NEXT.
  - NEXT -> A_SETUP (next enabled field, or commit).
  - NEXT after the commit write -> DONE.
  - DONE -> IDLE after one cycle.
- Phase counter runs 0..T_PH-1 and the phase advances at T_PH-1.
- WR and AD never change in the same clock edge as the WR falling edge. Address/data are stable for T_PH clocks before and after every WR low pulse.
- done = 1 exactly in the DONE cycle; busy drops in that same cycle.
- Latency: with N enabled fields, start accepted at cycle 0, DONE occurs at cycle 1 + (N+1)*(6*T_PH + 1).
  - Defaults, all fields enabled: 1 + 10*25 = 251.
  - Mask = 0: 26.
- RD is constant 1 in all states.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package rtc_pkg holds:
  - RTC register address constants (21h..26h, 41h..43h, F1h).
  - Field-index enum (S, M, H, D, ME, A, ST, MT, HT, COMMIT).
  - Bus-phase state enum.
- Shared package constants are reused by the reader.
- Sub-module rtc_bus_cycle:
  - Ports: go, addr, data -> pin outputs, cycle_done.
  - Implements the six phases plus the gap.
  - rtc_write_sequencer provides field selection, snapshot and mask walking on top of it.

Test Plan:
1. Reset, then start with mask=1FFh, s_e=45h..ht_e=12h, T_PH=4 -> ten writes in order to 21h..26h, 41h..43h, F1h with correct data. Each WR low pulse is 4 clocks, CS low 24 clocks per write, done at cycle 251, RD never 0.
2. mask=001000100b (h, st) -> exactly three writes (23h, 41h, F1h); done at cycle 1+3*25 = 76.
3. mask=0 -> only the F1h/00h commit write; done at cycle 26.
4. Second start pulse at cycle 30 and s_e changed at cycle 40 -> ignored. Written s value equals the snapshot; done fires once.
5. rst asserted mid D_STB of the third write -> same cycle: WR=1, CS=1, bus_oe=0, busy=0. A new start afterward restarts from the first enabled field.
6. T_PH=1 -> each write is 7 cycles. Bus monitor confirms addr/data stable at both WR edges with no AD/WR same-edge transitions.
